sample_walker: RTL and testbench

//  Bounding-box sample iterator; feeds the sample-test stage.

---
 rtl/sample_walker_pkg.sv | 31 +++
 rtl/sample_walker_if.sv | 26 ++
 rtl/sample_walker.sv | 87 ++++++++
 tb/tb_sample_walker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_walker_pkg.sv
// Shared types, sizes and the step decoder for the bounding-box sample walker.
package sample_walker_pkg;

   localparam int unsigned SIGFIG = 24;
   localparam int unsigned RADIX  = 10;
   localparam int unsigned VERTS  = 3;
   localparam int unsigned AXIS   = 3;
   localparam int unsigned COLORS = 3;

   typedef logic signed [SIGFIG-1:0]                word_t;
   typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_t;
   typedef logic [COLORS-1:0][SIGFIG-1:0]           color_t;
   typedef logic [1:0][1:0][SIGFIG-1:0]             box_t;     // [0]=LL, [1]=UR; [n][0]=x
   typedef logic [1:0][SIGFIG-1:0]                  sample_t;  // [0]=x, [1]=y

   typedef enum logic {WAIT, TEST} walk_state_t;

   // Anything that is not a clean one-hot code falls back to a whole-pixel step.
   function automatic word_t step_from_subsample(input logic [3:0] sub, input int unsigned radix);
      int unsigned k;
      case (sub)
         4'b1000: k = 0;
         4'b0100: k = 1;
         4'b0010: k = 2;
         4'b0001: k = 3;
         default: k = 0;
      endcase
      return word_t'(1) << (radix - k);
   endfunction

endpackage

// File: rtl/sample_walker_if.sv
// R13 input bundle from the bbox stage and R14 output bundle to the sample tester.
interface sample_walker_if;
   import sample_walker_pkg::*;

   tri_t        tri_R13S;
   color_t      color_R13U;
   box_t        box_R13S;
   logic        validTri_R13H;
   logic [3:0]  subSample_RnnnnU;
   logic        halt_RnnnnL;
   tri_t        tri_R14S;
   color_t      color_R14U;
   sample_t     sample_R14S;
   logic        validSamp_R14H;

   modport slave (
      input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
      output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
   );

   modport master (
      output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
      input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
   );

endinterface

// File: rtl/sample_walker.sv
// Walks every subsample of a grid-aligned bounding box in raster order, one sample per cycle,
// holding the upstream stage while a walk is in progress.
module sample_walker
   import sample_walker_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   sample_walker_if.slave   bus
);

   walk_state_t state_q;
   tri_t        tri_q;
   color_t      color_q;
   box_t        box_q;
   word_t       step_q;
   sample_t     sample_q;
   logic        valid_q;

   word_t cur_x, cur_y, ur_x, ur_y, ll_x;
   word_t x_nxt, y_nxt;
   logic  last_samp;

   assign cur_x = word_t'(sample_q[0]);
   assign cur_y = word_t'(sample_q[1]);
   assign ll_x  = word_t'(box_q[0][0]);
   assign ur_x  = word_t'(box_q[1][0]);
   assign ur_y  = word_t'(box_q[1][1]);

   always_comb begin
      x_nxt     = cur_x;
      y_nxt     = cur_y;
      last_samp = 1'b0;
      if (cur_x < ur_x) begin
         x_nxt = cur_x + step_q;
      end else if (cur_y < ur_y) begin
         x_nxt = ll_x;
         y_nxt = cur_y + step_q;
      end else begin
         last_samp = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= WAIT;
         tri_q    <= '0;
         color_q  <= '0;
         box_q    <= '0;
         step_q   <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            WAIT: begin
               if (bus.validTri_R13H) begin
                  tri_q    <= bus.tri_R13S;
                  color_q  <= bus.color_R13U;
                  box_q    <= bus.box_R13S;
                  step_q   <= step_from_subsample(bus.subSample_RnnnnU, RADIX);
                  sample_q <= bus.box_R13S[0];
                  valid_q  <= 1'b1;
                  state_q  <= TEST;
               end else begin
                  valid_q  <= 1'b0;
               end
            end
            TEST: begin
               // The last sample keeps its position; only valid drops on the way back to WAIT.
               if (last_samp) begin
                  valid_q  <= 1'b0;
                  state_q  <= WAIT;
               end else begin
                  sample_q <= {y_nxt, x_nxt};
               end
            end
            default: state_q <= WAIT;
         endcase
      end
   end

   assign bus.halt_RnnnnL    = (state_q == WAIT);
   assign bus.tri_R14S       = tri_q;
   assign bus.color_R14U     = color_q;
   assign bus.sample_R14S    = sample_q;
   assign bus.validSamp_R14H = valid_q;

endmodule

// File: tb/tb_sample_walker.sv
// Randomised scoreboard bench for sample_walker: stimulus pushes expected samples,
// a negedge monitor pops and compares whatever the walker emits.
module tb_sample_walker;
   import sample_walker_pkg::*;

   typedef struct {
      int     x;
      int     y;
      tri_t   t;
      color_t c;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sample_walker_if bus ();

   sample_walker dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   len_q[$];
   int   run_start_q[$];
   int   run_end_q[$];

   int     n_checks = 0;
   int     n_pass   = 0;
   bit     abort    = 1'b0;
   int     cyc      = 0;
   int     run_len  = 0;
   int     run_start = 0;
   int     run_last  = 0;
   tri_t   last_t   = '0;
   color_t last_c   = '0;
   exp_t   mon_e;
   logic [SIGFIG-1:0] exp_x, exp_y;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   // Sample spacing straight from the table: one pixel divided by 1, 2, 4 or 8.
   function automatic int ref_step(input logic [3:0] sub);
      case (sub)
         4'b1000: return 1024;
         4'b0100: return 512;
         4'b0010: return 256;
         4'b0001: return 128;
         default: return 1024;
      endcase
   endfunction

   // Monitor / scoreboard.
   always @(negedge clk) begin
      cyc++;
      check("halt_vs_valid", bus.halt_RnnnnL, !bus.validSamp_R14H);
      if (bus.validSamp_R14H) begin
         if (run_len == 0) run_start = cyc;
         run_last = cyc;
         run_len++;
         check("sample_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            exp_x = mon_e.x[SIGFIG-1:0];
            exp_y = mon_e.y[SIGFIG-1:0];
            check("sample_x", bus.sample_R14S[0], exp_x);
            check("sample_y", bus.sample_R14S[1], exp_y);
            check("tri_walk", bus.tri_R14S, mon_e.t);
            check("color_walk", bus.color_R14U, mon_e.c);
            last_t = mon_e.t;
            last_c = mon_e.c;
         end
      end else begin
         if (run_len > 0) begin
            if (abort) begin
               abort = 1'b0;
               if (len_q.size() != 0) void'(len_q.pop_front());
               last_t = '0;
               last_c = '0;
            end else begin
               check("run_expected", len_q.size() != 0, 1'b1);
               if (len_q.size() != 0) check("run_length", run_len, len_q.pop_front());
               run_start_q.push_back(run_start);
               run_end_q.push_back(run_last);
            end
            run_len = 0;
         end
         check("tri_hold", bus.tri_R14S, last_t);
         check("color_hold", bus.color_R14U, last_c);
      end
   end

   // Called at negedge+1; returns at negedge+1 of the first-sample cycle with validTri still high.
   task automatic offer(input int llx, input int lly, input int urx, input int ury,
                        input logic [3:0] sub);
      tri_t   t;
      color_t c;
      int     step;
      int     n;
      bit     ok;
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++) t[v][a] = SIGFIG'($urandom);
      for (int k = 0; k < COLORS; k++) c[k] = SIGFIG'($urandom);
      bus.tri_R13S         = t;
      bus.color_R13U       = c;
      bus.box_R13S[0][0]   = SIGFIG'(llx);
      bus.box_R13S[0][1]   = SIGFIG'(lly);
      bus.box_R13S[1][0]   = SIGFIG'(urx);
      bus.box_R13S[1][1]   = SIGFIG'(ury);
      bus.subSample_RnnnnU = sub;
      bus.validTri_R13H    = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (bus.halt_RnnnnL) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      check("accept_in_time", ok, 1'b1);
      if (ok) begin
         step = ref_step(sub);
         n = 0;
         for (int y = lly; y <= ury; y += step)
            for (int x = llx; x <= urx; x += step) begin
               exp_q.push_back('{x: x, y: y, t: t, c: c});
               n++;
            end
         len_q.push_back(n);
      end
      @(negedge clk); #1;
      if (ok) check("first_latency", bus.validSamp_R14H, 1'b1);
      // Upstream scribbles on its inputs mid-walk; the walker must not notice.
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++) bus.tri_R13S[v][a] = SIGFIG'($urandom);
      bus.color_R13U       = {COLORS{SIGFIG'($urandom)}};
      bus.box_R13S         = {4{SIGFIG'($urandom)}};
      bus.subSample_RnnnnU = 4'($urandom);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (exp_q.size() == 0 && bus.halt_RnnnnL && !bus.validSamp_R14H && run_len == 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      check("walk_finished", ok, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int sub, st, llx, lly, w, h;
      bus.tri_R13S         = '0;
      bus.color_R13U       = '0;
      bus.box_R13S         = '0;
      bus.validTri_R13H    = 1'b0;
      bus.subSample_RnnnnU = 4'b1000;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", bus.validSamp_R14H, 1'b0);
      check("rst_halt", bus.halt_RnnnnL, 1'b1);
      check("rst_sample", bus.sample_R14S, '0);
      check("rst_tri", bus.tri_R14S, '0);
      check("rst_color", bus.color_R14U, '0);
      rst = 1'b0;
      @(negedge clk); #1;
      check("post_rst_halt", bus.halt_RnnnnL, 1'b1);

      offer(0, 0, 2048, 1024, 4'b1000);            // 3x2 pixel box
      bus.validTri_R13H = 1'b0;
      wait_idle();
      offer(0, 0, 0, 0, 4'b1000);                  // single sample
      bus.validTri_R13H = 1'b0;
      wait_idle();
      offer(0, 0, 128, 128, 4'b0001);              // eighth-pixel step
      bus.validTri_R13H = 1'b0;
      wait_idle();
      offer(-1024, -1024, 0, -1024, 4'b1000);      // negative coordinates
      bus.validTri_R13H = 1'b0;
      wait_idle();

      // Back-to-back: validTri never drops between the two triangles.
      offer(0, 0, 1024, 0, 4'b1000);
      offer(512, 0, 1024, 512, 4'b0100);
      bus.validTri_R13H = 1'b0;
      wait_idle();
      check("b2b_runs_seen", run_end_q.size() >= 2, 1'b1);
      if (run_end_q.size() >= 2)
         check("b2b_gap", run_start_q[$] - run_end_q[$-1], 2);

      repeat (20) begin
         sub = $urandom_range(0, 15);
         st  = ref_step(4'(sub));
         llx = (int'($urandom_range(0, 16)) - 8) * st;
         lly = (int'($urandom_range(0, 16)) - 8) * st;
         w   = $urandom_range(0, 3);
         h   = $urandom_range(0, 3);
         offer(llx, lly, llx + w * st, lly + h * st, 4'(sub));
         bus.validTri_R13H = 1'b0;
         wait_idle();
      end

      // Reset during the third sample of a 6-sample walk.
      offer(0, 0, 2048, 1024, 4'b1000);
      bus.validTri_R13H = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("third_valid", bus.validSamp_R14H, 1'b1);
      check("third_x", bus.sample_R14S[0], SIGFIG'(2048));
      rst = 1'b1;
      #1;
      check("abort_valid", bus.validSamp_R14H, 1'b0);
      check("abort_halt", bus.halt_RnnnnL, 1'b1);
      check("abort_sample", bus.sample_R14S, '0);
      check("abort_tri", bus.tri_R14S, '0);
      exp_q.delete();
      abort = 1'b1;
      #1;
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk); #1;
         check("no_resume", bus.validSamp_R14H, 1'b0);
      end
      offer(-2048, 1024, -1024, 1024, 4'b1000);
      bus.validTri_R13H = 1'b0;
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
